// File: rtl/glyph_pkg.sv
// Shared 3x5 hex glyph set for the glyph scanner and its ROM.
// Row r occupies bits [14-3r:12-3r]; column c (0 = left) is bit 12-3r+c.
package glyph_pkg;

  localparam int GLYPH_W = 3;
  localparam int GLYPH_H = 5;

  typedef logic [14:0] glyph_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  // Each triple is written col2,col1,col0, so it reads mirrored versus the screen.
  localparam glyph_t GLYPHS [16] = '{
    15'b111_101_101_101_111, // 0
    15'b100_100_100_100_100, // 1
    15'b111_100_111_001_111, // 2
    15'b111_100_111_100_111, // 3
    15'b101_101_111_100_100, // 4
    15'b111_001_111_100_111, // 5
    15'b111_001_111_101_111, // 6
    15'b111_100_100_100_100, // 7
    15'b111_101_111_101_111, // 8
    15'b111_101_111_100_111, // 9
    15'b111_101_111_101_101, // A
    15'b011_101_011_101_011, // B
    15'b111_001_001_001_111, // C
    15'b011_101_101_101_011, // D
    15'b111_001_111_001_111, // E
    15'b111_001_111_001_001  // F
  };

  function automatic logic [2:0] glyph_row(input glyph_t g, input logic [2:0] row);
    case (row)
      3'd0:    return g[14:12];
      3'd1:    return g[11:9];
      3'd2:    return g[8:6];
      3'd3:    return g[5:3];
      3'd4:    return g[2:0];
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic glyph_bit(input logic [3:0] nibble, input logic [2:0] row,
                                     input logic [1:0] col);
    logic [2:0] r;
    r = glyph_row(GLYPHS[nibble], row);
    return (col != 2'd3) ? r[col] : 1'b0;
  endfunction

endpackage

// File: rtl/hex_glyph_rom.sv
// Combinational nibble -> 15-bit glyph lookup.
module hex_glyph_rom
  import glyph_pkg::*;
(
  input  logic [3:0]  nibble_i,
  input  logic [14:0] unused_i,
  output logic [14:0] glyph_o
);
  assign glyph_o = GLYPHS[nibble_i];
endmodule

// File: rtl/hex_glyph_scanner.sv
// Streams an N-digit hex value as a scaled 3x5 glyph raster over valid/ready,
// one pixel per accepted beat, with end-of-line / end-of-frame flags.
module hex_glyph_scanner
  import glyph_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int GAP_COLS = 1,
  parameter int SCALE    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic                    blank_lz,
  output logic                    busy,
  output logic                    done,
  output logic                    pix,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic                    pix_eol,
  output logic                    pix_eof
);

  localparam int X_W   = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int COL_W = $clog2(GLYPH_W + GAP_COLS);
  localparam int DIG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int ROW_W = $clog2(GLYPH_H);

  localparam logic [X_W-1:0]   X_LAST         = X_W'(SCALE - 1);
  localparam logic [COL_W-1:0] COL_GLYPH_LAST = COL_W'(GLYPH_W - 1);
  localparam logic [COL_W-1:0] COL_CELL_LAST  = COL_W'(GLYPH_W - 1 + GAP_COLS);
  localparam logic [DIG_W-1:0] DIG_FIRST      = DIG_W'(N_DIGITS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST       = ROW_W'(GLYPH_H - 1);

  scan_state_e             state_q, state_d;
  logic [X_W-1:0]          xr_q, xr_d, yr_q, yr_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [DIG_W-1:0]        dig_q, dig_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [4*N_DIGITS-1:0]   value_q, value_d;
  logic [N_DIGITS-1:0]     mask_q, mask_d;
  logic                    pix_q, pix_d, eol_q, eol_d, eof_q, eof_d, done_q, done_d;

  logic                    load_px, clear_px;
  logic [N_DIGITS-1:0]     lz_mask;
  logic [3:0]              nib [N_DIGITS];
  logic [3:0]              nib_sel;
  logic [14:0]             glyph_sel;
  logic [2:0]              row_bits;
  logic [COL_W-1:0]        col_last;
  logic                    px_calc, eol_calc, eof_calc;

  // Digit i blanks only when it and every more-significant digit are zero.
  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_lsd
        assign lz_mask[gi] = 1'b0;
      end else begin : g_upper
        assign lz_mask[gi] = blank_lz && (value[4*N_DIGITS-1:4*gi] == '0);
      end
      assign nib[gi] = value_d[4*gi +: 4];
    end
  endgenerate

  assign nib_sel = nib[dig_d];

  hex_glyph_rom u_rom (
    .nibble_i (nib_sel),
    .unused_i (15'd0),
    .glyph_o  (glyph_sel)
  );

  assign col_last = (dig_q == '0) ? COL_GLYPH_LAST : COL_CELL_LAST;

  always_comb begin
    state_d  = state_q;
    xr_d     = xr_q;
    yr_d     = yr_q;
    col_d    = col_q;
    dig_d    = dig_q;
    row_d    = row_q;
    value_d  = value_q;
    mask_d   = mask_q;
    done_d   = 1'b0;
    load_px  = 1'b0;
    clear_px = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          value_d = value;
          mask_d  = lz_mask;
          xr_d    = '0;
          yr_d    = '0;
          col_d   = '0;
          dig_d   = DIG_FIRST;
          row_d   = '0;
          load_px = 1'b1;
        end
      end
      ST_SCAN: begin
        if (pix_ready) begin
          if (eof_q) begin
            state_d  = ST_IDLE;
            done_d   = 1'b1;
            clear_px = 1'b1;
          end else begin
            load_px = 1'b1;
            // Innermost first: x-replica, cell column, digit, y-replica, row.
            if (xr_q != X_LAST) begin
              xr_d = xr_q + 1'b1;
            end else begin
              xr_d = '0;
              if (col_q != col_last) begin
                col_d = col_q + 1'b1;
              end else begin
                col_d = '0;
                if (dig_q != '0) begin
                  dig_d = dig_q - 1'b1;
                end else begin
                  dig_d = DIG_FIRST;
                  if (yr_q != X_LAST) begin
                    yr_d = yr_q + 1'b1;
                  end else begin
                    yr_d  = '0;
                    row_d = row_q + 1'b1;
                  end
                end
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next position so they line up with the counters.
  always_comb begin
    row_bits = glyph_row(glyph_sel, 3'(row_d));
    px_calc  = (col_d <= COL_GLYPH_LAST) && !mask_d[dig_d] && row_bits[col_d[1:0]];
    eol_calc = (xr_d == X_LAST) && (col_d == COL_GLYPH_LAST) && (dig_d == '0);
    eof_calc = eol_calc && (yr_d == X_LAST) && (row_d == ROW_LAST);
    pix_d    = pix_q;
    eol_d    = eol_q;
    eof_d    = eof_q;
    if (load_px) begin
      pix_d = px_calc;
      eol_d = eol_calc;
      eof_d = eof_calc;
    end else if (clear_px) begin
      pix_d = 1'b0;
      eol_d = 1'b0;
      eof_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      col_q   <= '0;
      dig_q   <= '0;
      row_q   <= '0;
      value_q <= '0;
      mask_q  <= '0;
      pix_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      col_q   <= col_d;
      dig_q   <= dig_d;
      row_q   <= row_d;
      value_q <= value_d;
      mask_q  <= mask_d;
      pix_q   <= pix_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == ST_SCAN);
  assign pix_valid = (state_q == ST_SCAN);
  assign pix       = pix_q;
  assign pix_eol   = eol_q;
  assign pix_eof   = eof_q;
  assign done      = done_q;

endmodule

// File: tb/tb_hex_glyph_scanner.sv
// Self-checking bench: two scanner instances (SCALE 1 and 2), table-driven frames
// checked against a scoreboard built from an on-screen glyph model.
module tb_hex_glyph_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start1 = 1'b0, start2 = 1'b0;
  logic [7:0] value = 8'h00;
  logic       blank_lz = 1'b0;
  logic       pix_ready = 1'b1;

  logic busy1, done1, pix1, valid1, eol1, eof1;
  logic busy2, done2, pix2, valid2, eol2, eof2;
  logic s_busy, s_done, s_pix, s_valid, s_eol, s_eof;
  int   sel = 1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hex_glyph_scanner #(.N_DIGITS(2), .GAP_COLS(1), .SCALE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .value(value), .blank_lz(blank_lz),
    .busy(busy1), .done(done1), .pix(pix1), .pix_valid(valid1), .pix_ready(pix_ready),
    .pix_eol(eol1), .pix_eof(eof1)
  );

  hex_glyph_scanner #(.N_DIGITS(2), .GAP_COLS(1), .SCALE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .value(value), .blank_lz(blank_lz),
    .busy(busy2), .done(done2), .pix(pix2), .pix_valid(valid2), .pix_ready(pix_ready),
    .pix_eol(eol2), .pix_eof(eof2)
  );

  always_comb begin
    if (sel == 2) begin
      {s_busy, s_done, s_pix, s_valid, s_eol, s_eof} = {busy2, done2, pix2, valid2, eol2, eof2};
    end else begin
      {s_busy, s_done, s_pix, s_valid, s_eol, s_eof} = {busy1, done1, pix1, valid1, eol1, eof1};
    end
  end

  typedef struct packed {
    logic pix;
    logic eol;
    logic eof;
  } px_t;
  px_t exp_q[$];

  typedef struct {
    int          which;
    logic [7:0]  v;
    logic        lz;
    logic [13:0] r0;
    logic [13:0] r1;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // On-screen glyphs: top row first, each triple reads left to right.
  function automatic logic [14:0] vis_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 15'b111_101_101_101_111;
      4'h1: return 15'b001_001_001_001_001;
      4'h2: return 15'b111_001_111_100_111;
      4'h3: return 15'b111_001_111_001_111;
      4'h4: return 15'b101_101_111_001_001;
      4'h5: return 15'b111_100_111_001_111;
      4'h6: return 15'b111_100_111_101_111;
      4'h7: return 15'b111_001_001_001_001;
      4'h8: return 15'b111_101_111_101_111;
      4'h9: return 15'b111_101_111_001_111;
      4'hA: return 15'b111_101_111_101_101;
      4'hB: return 15'b110_101_110_101_110;
      4'hC: return 15'b111_100_100_100_111;
      4'hD: return 15'b110_101_101_101_110;
      4'hE: return 15'b111_100_111_100_111;
      default: return 15'b111_100_111_100_100;
    endcase
  endfunction

  task automatic push_frame(input logic [7:0] v, input logic lz, input int sc);
    int w = 7 * sc;
    int h = 5 * sc;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        int sx = x / sc;
        int c  = sx % 4;
        int di = 1 - (sx / 4);
        logic [3:0]  nibv;
        logic [14:0] g;
        logic [14:0] gs;
        logic        blank;
        px_t         e;
        nibv  = (di == 1) ? v[7:4] : v[3:0];
        blank = lz && (di == 1) && (v[7:4] == 4'h0);
        g     = vis_glyph(nibv);
        gs    = g >> (3 * (4 - y / sc));
        e.pix = (c < 3) && !blank && gs[2 - c];
        e.eol = (x == w - 1);
        e.eof = (x == w - 1) && (y == h - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Called on a negedge; returns on the done-cycle negedge (or after an abort).
  task automatic run_frame(input int which, input logic [7:0] v, input logic lz,
                           input int stall_at, input int stall_len, input bit probe_start,
                           input int abort_at, input logic [13:0] exp_r0,
                           input logic [13:0] exp_r1);
    int sc = (which == 2) ? 2 : 1;
    int w = 7 * sc;
    int total = 35 * sc * sc;
    int cnt = 0;
    int budget = 0;
    int stall_left = 0;
    bit stalled = 1'b0;
    bit last = 1'b0;
    logic [13:0] r0 = '0;
    logic [13:0] r1 = '0;
    px_t e;
    sel = which;
    exp_q.delete();
    push_frame(v, lz, sc);
    value = v;
    blank_lz = lz;
    pix_ready = 1'b1;
    if (which == 2) start2 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    check("first_valid", s_valid, 1);
    check("busy_on", s_busy, 1);
    value = ~v;
    while (!last && budget < 600) begin
      budget++;
      if (abort_at > 0 && cnt + 1 == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_outputs", {s_busy, s_done, s_pix, s_valid, s_eol, s_eof}, 6'b0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("rst_no_done", {s_done, s_valid}, 2'b0);
        end
        exp_q.delete();
        $display("frame dut=%0d value=%02h aborted after %0d pixels", which, v, cnt);
        return;
      end
      if (!stalled && stall_len > 0 && cnt + 1 == stall_at) begin
        stalled = 1'b1;
        stall_left = stall_len;
      end
      pix_ready = (stall_left == 0);
      if (!s_valid) begin
        check("valid_hold", s_valid, 1);
      end else if (exp_q.size() == 0) begin
        check("overrun", 1, 0);
        last = 1'b1;
      end else if (pix_ready) begin
        e = exp_q.pop_front();
        cnt++;
        check("pix", s_pix, e.pix);
        check("eol", s_eol, e.eol);
        check("eof", s_eof, e.eof);
        if (cnt <= w) r0 = {r0[12:0], s_pix};
        else if (cnt <= 2 * w) r1 = {r1[12:0], s_pix};
        last = e.eof;
        if (probe_start && (cnt == 5 || last)) begin
          if (which == 2) start2 = 1'b1; else start1 = 1'b1;
        end
      end else begin
        e = exp_q[0];
        check("stall_stable", {s_pix, s_eol, s_eof}, {e.pix, e.eol, e.eof});
        stall_left--;
      end
      @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
    end
    pix_ready = 1'b1;
    if (!last) check("frame_timeout", 0, 1);
    check("done_pulse", s_done, 1);
    check("valid_off", s_valid, 0);
    check("busy_off", s_busy, 0);
    check("pixel_count", cnt, total);
    check("row0", r0, exp_r0);
    check("row1", r1, exp_r1);
    $display("frame dut=%0d value=%02h lz=%0d pixels=%0d row0=%b row1=%b",
             which, v, lz, cnt, r0, r1);
    if (probe_start) begin
      @(negedge clk);
      check("start_ignored", s_valid, 0);
      check("done_single", s_done, 0);
    end
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1, 8'h10, 1'b0, 14'b00000000010111, 14'b00000000010101};
    vecs[1] = '{1, 8'h05, 1'b1, 14'b00000000000111, 14'b00000000000100};
    vecs[2] = '{1, 8'h00, 1'b1, 14'b00000000000111, 14'b00000000000101};
    vecs[3] = '{1, 8'h50, 1'b1, 14'b00000001110111, 14'b00000001000101};
    vecs[4] = '{1, 8'h00, 1'b0, 14'b00000001110111, 14'b00000001010101};
    vecs[5] = '{1, 8'h2A, 1'b0, 14'b00000001110111, 14'b00000000010101};
    vecs[6] = '{1, 8'hB4, 1'b0, 14'b00000001100101, 14'b00000001010101};
    vecs[7] = '{2, 8'h10, 1'b0, 14'b00001100111111, 14'b00001100111111};

    repeat (3) @(negedge clk);
    check("reset_dut1", {busy1, done1, pix1, valid1, eol1, eof1}, 6'b0);
    check("reset_dut2", {busy2, done2, pix2, valid2, eol2, eof2}, 6'b0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_frame(vecs[i].which, vecs[i].v, vecs[i].lz, 0, 0, 1'b0, 0, vecs[i].r0, vecs[i].r1);
      @(negedge clk);
    end

    // Backpressure: ready held low for three cycles while pixel 9 is presented.
    run_frame(1, 8'h10, 1'b0, 9, 3, 1'b0, 0, vecs[0].r0, vecs[0].r1);
    @(negedge clk);

    // start pulses while busy and on the last-acceptance cycle.
    run_frame(1, 8'h2A, 1'b0, 0, 0, 1'b1, 0, vecs[5].r0, vecs[5].r1);
    @(negedge clk);

    // Second start lands on the done cycle of the first.
    run_frame(1, 8'h10, 1'b0, 0, 0, 1'b0, 0, vecs[0].r0, vecs[0].r1);
    run_frame(1, 8'h05, 1'b1, 0, 0, 1'b0, 0, vecs[1].r0, vecs[1].r1);
    @(negedge clk);

    // Reset at pixel 20, then a complete frame from pixel 1.
    run_frame(1, 8'h10, 1'b0, 0, 0, 1'b0, 20, vecs[0].r0, vecs[0].r1);
    @(negedge clk);
    run_frame(1, 8'h50, 1'b1, 0, 0, 1'b0, 0, vecs[3].r0, vecs[3].r1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_glyph_scanner.md
Name: hex_glyph_scanner

Overview:
- Renders an N-digit hex value as a raster of 3x5 glyph pixels, with optional integer scaling, inter-digit gap columns and leading-zero blanking.
- Emits one pixel per accepted beat in row-major order over a valid/ready stream, with end-of-line and end-of-frame flags.
- Sits between a value source (score or register readout) and the display pixel writer.
- Successor to the two-digit combinational glyph decoder; uses the same 15-bit glyph encoding.

Parameters:
- N_DIGITS, 4, number of hex digits rendered; value width is 4*N_DIGITS; allowed range 1..8.
- GAP_COLS, 1, blank source columns between adjacent digits; none before the first or after the last digit; 0 allowed.
- SCALE, 1, pixel replication factor, applied to both x and y; allowed range 1..4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  load request; honoured only when busy=0.
- value  in  4*N_DIGITS  hex value; digit N_DIGITS-1 is the most significant and leftmost.
- blank_lz  in  1  leading-zero blanking enable, latched with value.
- busy  out  1  high from the cycle after an accepted start until the last pixel is accepted.
- done  out  1  one-cycle pulse, the cycle after the last pixel is accepted.
- pix  out  1  current pixel (1 = lit).
- pix_valid  out  1  pixel valid.
- pix_ready  in  1  sink ready.
- pix_eol  out  1  current pixel is the last in its line.
- pix_eof  out  1  current pixel is the last in the frame.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - busy, done, pix_valid, pix, pix_eol and pix_eof all go to 0.
  - All counters and the FSM go to IDLE.
  - A reset mid-frame aborts the frame with no done pulse.
- Frame geometry:
  - W = SCALE*(3*N_DIGITS + GAP_COLS*(N_DIGITS-1)).
  - H = 5*SCALE.
  - Pixel count = W*H.
- Glyph encoding, 15 bits, stored in the package:
  - Source row r (0 = top) occupies bits [14-3r : 12-3r].
  - Column c (0 = left) is bit 12-3r+c.
  - Example: "2" = 111 100 111 001 111, whose second row lights only the right pixel.
- FSM, IDLE -> SCAN -> IDLE:
  - In IDLE, start=1 latches value and blank_lz, builds the blank mask, enters SCAN, and raises busy and pix_valid on the next cycle. Latency from start to first valid pixel is 1 cycle.
  - In SCAN, pix_valid stays 1 throughout.
  - In SCAN, pixel/flag outputs advance only on pix_valid & pix_ready. When pix_ready=0, pix, pix_eol and pix_eof hold stable.
- Scan order, innermost counter first:
  - x-replica (0..SCALE-1).
  - Column within the digit cell (0..2 glyph, then 3..2+GAP_COLS gap; the gap is skipped after the last digit).
  - Digit (N_DIGITS-1 down to 0).
  - y-replica (0..SCALE-1).
  - Source row (0..4).
- Pixel value:
  - Gap columns output 0.
  - Blanked digits output 0.
  - Otherwise pix = glyph bit of that digit at (row, col).
- Flags:
  - pix_eol=1 on the last x position of each line.
  - pix_eof=1 only on the final pixel; pix_eol is also 1 there.
- Last pixel:
  - When the pixel with pix_eof=1 is accepted, the next cycle has pix_valid=0, busy=0 and done=1, and the FSM returns to IDLE.
  - Back-to-back frames therefore have at least one idle cycle between them.
- Leading-zero blanking:
  - Mask computed at load.
  - Digit i is blanked iff blank_lz=1, digit i is 0, all more-significant digits are 0, and i != 0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Start handling:
  - start is ignored while busy=1, including the cycle the last pixel is accepted.
  - Inputs are not sampled during SCAN; changes to value mid-frame have no effect.
- Power-up:
  - Counter widths are sized from the parameters with $clog2.
  - No X propagation on outputs after the first reset.

Decomposition:
- glyph_pkg:
  - GLYPH_W=3 and GLYPH_H=5.
  - 16-entry array of 15-bit glyph constants (0..F).
  - Function glyph_bit(nibble, row, col).
- Sub-module hex_glyph_rom: combinational nibble -> 15-bit glyph.
- hex_glyph_scanner holds the FSM, counters, blank mask and registered outputs.

Test Plan:
- Basic raster (N_DIGITS=2, GAP_COLS=1, SCALE=1, pix_ready=1), value=8'h10, blank_lz=0:
  - W=7, 35 pixels.
  - Row 0 = 0,0,1,0,1,1,1; row 1 = 0,0,1,0,1,0,1.
  - pix_eol on pixels 7,14,...,35; pix_eof on pixel 35; done one cycle later.
- Leading-zero blanking (same config), blank_lz=1:
  - value=8'h05: row 0 = 0,0,0,0,1,1,1.
  - value=8'h00: row 0 = 0,0,0,0,1,1,1 (digit 0 still shown).
  - value=8'h50: row 0 = 1,1,1,0,1,1,1.
- Scaling (SCALE=2, value=8'h10): W=14, H=10, 140 pixels; rows 0 and 1 both = 0,0,0,0,1,1,0,0,1,1,1,1,1,1.
- Backpressure: pix_ready low for 3 cycles at pixel 9 -> pix, pix_eol and pix_eof stable; no pixel dropped or duplicated; total count still 35.
- Start handling:
  - start pulsed while busy, and on the cycle of last-pixel acceptance -> ignored.
  - start on the done cycle -> new frame, first pixel valid the following cycle.
- Reset mid-frame: rst_n=0 for one cycle at pixel 20 -> next cycle all outputs 0, no done pulse; a subsequent start renders a full frame from pixel 1.
